// File: rtl/norm_seq.sv
// norm_seq: per-row normalization sequencer for one attention core.
// Pops each psum row from the ofifo so the SFP can accumulate its local sum.
// In dual-core mode it trades that sum with the peer core over the
// inter-core FIFO. It then drives the divide pass and the pmem write-back.
// The top-level controller only issues start and waits for done.
module norm_seq #(
  parameter int ROWS    = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          solo,
  input  logic          ofifo_valid,
  output logic          ofifo_rd,
  output logic          acc_en,
  input  logic          int_fifo_full,
  output logic          sum_wr,
  input  logic          peer_valid,
  output logic          peer_rd,
  output logic          div_en,
  output logic          pmem_wr,
  output logic [AW-1:0] pmem_addr,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // The timeout counter must be able to hold TIMEOUT itself.
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_XMIT,
    S_WAIT,
    S_DIV,
    S_WB,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] row_q, row_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;
  logic          solo_q, solo_d;

  // Next-state logic for the sequencer, the row and timeout counters, the error flag and the solo latch.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    solo_d  = solo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          solo_d  = solo;
          row_d   = '0;
          tcnt_d  = '0;
          err_d   = 1'b0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (ofifo_valid) begin
          state_d = solo_q ? S_DIV : S_XMIT;
        end
      end
      S_XMIT: begin
        if (!int_fifo_full) begin
          tcnt_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A peer sum showing up on the last allowed cycle still wins over the timeout.
        if (peer_valid) begin
          state_d = S_DIV;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (tcnt_q == TW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DIV: begin
        state_d = S_WB;
      end
      S_WB: begin
        // row stays at ROWS-1 after the last row. It is cleared by the next start.
        if (row_q == AW'(ROWS - 1)) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + AW'(1);
          state_d = S_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register all sequencer state. A synchronous reset drops any tile in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      solo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      solo_q  <= solo_d;
    end
  end

  // Each handshake is qualified by its ready input, so it fires on exactly one cycle per row.
  assign ofifo_rd  = (state_q == S_RD) && ofifo_valid;
  assign acc_en    = ofifo_rd;
  assign sum_wr    = (state_q == S_XMIT) && !int_fifo_full;
  assign peer_rd   = (state_q == S_WAIT) && peer_valid;
  assign div_en    = (state_q == S_DIV);
  assign pmem_wr   = (state_q == S_WB);
  assign pmem_addr = row_q;
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_norm_seq.sv
// tb_norm_seq: directed testbench for norm_seq with ROWS=8, AW=3, TIMEOUT=10.
// Cycle 0 is the cycle in which start is driven. Cycle n is the n-th cycle after the edge that samples start.
module tb_norm_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       solo;
  logic       ofifo_valid;
  logic       ofifo_rd;
  logic       acc_en;
  logic       int_fifo_full;
  logic       sum_wr;
  logic       peer_valid;
  logic       peer_rd;
  logic       div_en;
  logic       pmem_wr;
  logic [2:0] pmem_addr;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  // Per-tile observations collected by run_tile
  int n_ofifo, n_acc, n_sum, n_peer, n_div, n_wr;
  int done_cyc, addr_bad, dbl_hs, sum_full;
  logic err_at_done, err_first, busy_first, busy_after, err_after;

  always #5 clk = ~clk;

  norm_seq #(.ROWS(8), .AW(3), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .solo(solo),
    .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd), .acc_en(acc_en),
    .int_fifo_full(int_fifo_full), .sum_wr(sum_wr),
    .peer_valid(peer_valid), .peer_rd(peer_rd),
    .div_en(div_en), .pmem_wr(pmem_wr), .pmem_addr(pmem_addr),
    .busy(busy), .done(done), .err(err)
  );

  // Hand-planned input pattern for each scenario, indexed by the tile cycle.
  task automatic drive_inputs(input int scen, input int cyc);
    ofifo_valid   = 1'b1;
    peer_valid    = 1'b1;
    int_fifo_full = 1'b0;
    case (scen)
      2: begin
        int_fifo_full = (cyc >= 12 && cyc <= 15);  // row 2 XMIT stalls 4 cycles
        ofifo_valid   = !(cyc >= 30 && cyc <= 32); // row 5 RD stalls 3 cycles
      end
      3: peer_valid = (cyc < 18);                  // row 3 WAIT starts at cycle 18 and never sees the peer
      4: peer_valid = !(cyc >= 18 && cyc <= 26);   // peer arrives on the 10th WAIT cycle
      default: ;
    endcase
  endtask

  // Start one tile and record handshake counts and timing until done or a 200-cycle budget.
  task automatic run_tile(input int scen, input logic solo_in);
    logic p_of, p_sw, p_pr;
    n_ofifo = 0; n_acc = 0; n_sum = 0; n_peer = 0; n_div = 0; n_wr = 0;
    done_cyc = -1; addr_bad = 0; dbl_hs = 0; sum_full = 0;
    err_at_done = 1'b0; err_first = 1'b1; busy_first = 1'b0;
    p_of = 1'b0; p_sw = 1'b0; p_pr = 1'b0;
    solo  = solo_in;
    start = 1'b1;
    drive_inputs(scen, 0);
    @(posedge clk); #1;
    start = 1'b0;
    solo  = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      drive_inputs(scen, cyc);
      #1;
      if (cyc == 1) begin err_first = err; busy_first = busy; end
      if (ofifo_rd) n_ofifo++;
      if (acc_en) n_acc++;
      if (sum_wr) n_sum++;
      if (peer_rd) n_peer++;
      if (div_en) n_div++;
      if (pmem_wr) begin
        if (int'(pmem_addr) != n_wr) addr_bad++;
        n_wr++;
      end
      if ((ofifo_rd && p_of) || (sum_wr && p_sw) || (peer_rd && p_pr)) dbl_hs++;
      if (sum_wr && int_fifo_full) sum_full++;
      p_of = ofifo_rd; p_sw = sum_wr; p_pr = peer_rd;
      if (done) begin
        done_cyc    = cyc;
        err_at_done = err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #2;
    busy_after = busy;
    err_after  = err;
  endtask

  // Reset state: every output low, even with all ready inputs asserted.
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; solo = 1'b0;
    ofifo_valid = 1'b1; peer_valid = 1'b1; int_fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({ofifo_rd, acc_en, sum_wr, peer_rd, div_en, pmem_wr, busy, done, err} !== 9'b0) begin errors++; $display("[TB] FAIL reset_outputs: got %b expected 000000000", {ofifo_rd, acc_en, sum_wr, peer_rd, div_en, pmem_wr, busy, done, err}); end
    checks++; if (pmem_addr !== 3'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", pmem_addr); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Dual mode with all inputs ready: 5 cycles per row, done on cycle 41.
  task automatic test_dual_nominal();
    run_tile(0, 1'b0);
    checks++; if (n_ofifo !== 8) begin errors++; $display("[TB] FAIL dual_ofifo_rd: got %0d expected 8", n_ofifo); end
    checks++; if (n_acc !== 8) begin errors++; $display("[TB] FAIL dual_acc_en: got %0d expected 8", n_acc); end
    checks++; if (n_sum !== 8) begin errors++; $display("[TB] FAIL dual_sum_wr: got %0d expected 8", n_sum); end
    checks++; if (n_peer !== 8) begin errors++; $display("[TB] FAIL dual_peer_rd: got %0d expected 8", n_peer); end
    checks++; if (n_div !== 8) begin errors++; $display("[TB] FAIL dual_div_en: got %0d expected 8", n_div); end
    checks++; if (n_wr !== 8) begin errors++; $display("[TB] FAIL dual_pmem_wr: got %0d expected 8", n_wr); end
    checks++; if (addr_bad !== 0) begin errors++; $display("[TB] FAIL dual_addr_seq: got %0d bad addresses expected 0", addr_bad); end
    checks++; if (done_cyc !== 41) begin errors++; $display("[TB] FAIL dual_done_cycle: got %0d expected 41", done_cyc); end
    checks++; if (err_at_done !== 1'b0) begin errors++; $display("[TB] FAIL dual_err: got %b expected 0", err_at_done); end
    checks++; if (dbl_hs !== 0) begin errors++; $display("[TB] FAIL dual_double_handshake: got %0d expected 0", dbl_hs); end
    checks++; if (busy_first !== 1'b1) begin errors++; $display("[TB] FAIL dual_busy_first: got %b expected 1", busy_first); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("[TB] FAIL dual_busy_after: got %b expected 0", busy_after); end
  endtask

  // Solo mode: no sum exchange, 3 cycles per row, done on cycle 25.
  task automatic test_solo();
    run_tile(1, 1'b1);
    checks++; if (n_sum !== 0) begin errors++; $display("[TB] FAIL solo_sum_wr: got %0d expected 0", n_sum); end
    checks++; if (n_peer !== 0) begin errors++; $display("[TB] FAIL solo_peer_rd: got %0d expected 0", n_peer); end
    checks++; if (n_ofifo !== 8) begin errors++; $display("[TB] FAIL solo_ofifo_rd: got %0d expected 8", n_ofifo); end
    checks++; if (n_wr !== 8) begin errors++; $display("[TB] FAIL solo_pmem_wr: got %0d expected 8", n_wr); end
    checks++; if (done_cyc !== 25) begin errors++; $display("[TB] FAIL solo_done_cycle: got %0d expected 25", done_cyc); end
  endtask

  // The int_fifo_full stall adds 4 cycles and the ofifo_valid stall adds 3, so done moves to cycle 48.
  task automatic test_stalls();
    run_tile(2, 1'b0);
    checks++; if (done_cyc !== 48) begin errors++; $display("[TB] FAIL stall_done_cycle: got %0d expected 48", done_cyc); end
    checks++; if (n_sum !== 8) begin errors++; $display("[TB] FAIL stall_sum_wr: got %0d expected 8", n_sum); end
    checks++; if (n_ofifo !== 8) begin errors++; $display("[TB] FAIL stall_ofifo_rd: got %0d expected 8", n_ofifo); end
    checks++; if (sum_full !== 0) begin errors++; $display("[TB] FAIL stall_sum_wr_when_full: got %0d expected 0", sum_full); end
    checks++; if (dbl_hs !== 0) begin errors++; $display("[TB] FAIL stall_double_handshake: got %0d expected 0", dbl_hs); end
    checks++; if (addr_bad !== 0) begin errors++; $display("[TB] FAIL stall_addr_seq: got %0d bad addresses expected 0", addr_bad); end
  endtask

  // No peer sum in row 3 WAIT (cycles 18..27): err is set and done follows on cycle 28 after 3 write-backs.
  task automatic test_timeout();
    run_tile(3, 1'b0);
    checks++; if (done_cyc !== 28) begin errors++; $display("[TB] FAIL timeout_done_cycle: got %0d expected 28", done_cyc); end
    checks++; if (err_at_done !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_at_done: got %b expected 1", err_at_done); end
    checks++; if (n_wr !== 3) begin errors++; $display("[TB] FAIL timeout_pmem_wr: got %0d expected 3", n_wr); end
    checks++; if (n_div !== 3) begin errors++; $display("[TB] FAIL timeout_div_en: got %0d expected 3", n_div); end
    checks++; if (err_after !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_sticky: got %b expected 1", err_after); end
    run_tile(0, 1'b0);
    checks++; if (err_first !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_cleared: got %b expected 0", err_first); end
    checks++; if (done_cyc !== 41) begin errors++; $display("[TB] FAIL timeout_rerun_done: got %0d expected 41", done_cyc); end
  endtask

  // The peer sum arrives on the last WAIT cycle before timeout. The pop wins and the tile runs 9 cycles late (done on cycle 50).
  task automatic test_peer_boundary();
    run_tile(4, 1'b0);
    checks++; if (n_peer !== 8) begin errors++; $display("[TB] FAIL boundary_peer_rd: got %0d expected 8", n_peer); end
    checks++; if (err_at_done !== 1'b0) begin errors++; $display("[TB] FAIL boundary_err: got %b expected 0", err_at_done); end
    checks++; if (n_wr !== 8) begin errors++; $display("[TB] FAIL boundary_pmem_wr: got %0d expected 8", n_wr); end
    checks++; if (done_cyc !== 50) begin errors++; $display("[TB] FAIL boundary_done_cycle: got %0d expected 50", done_cyc); end
  endtask

  // Reset lands in row 4 DIV (cycle 24). The tile is dropped and a fresh start runs all 8 rows from address 0.
  task automatic test_reset_mid_tile();
    int late_done;
    late_done = 0;
    solo = 1'b0; start = 1'b1;
    drive_inputs(0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 24; cyc++) begin
      drive_inputs(0, cyc);
      @(posedge clk); #1;
    end
    #1;
    checks++; if (div_en !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_div: got %b expected 1", div_en); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, pmem_wr, done, div_en} !== 4'b0) begin errors++; $display("[TB] FAIL midreset_outputs: got %b expected 0000", {busy, pmem_wr, done, div_en}); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) late_done++;
    end
    checks++; if (late_done !== 0) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d active cycles expected 0", late_done); end
    run_tile(0, 1'b0);
    checks++; if (n_wr !== 8) begin errors++; $display("[TB] FAIL midreset_rerun_wr: got %0d expected 8", n_wr); end
    checks++; if (addr_bad !== 0) begin errors++; $display("[TB] FAIL midreset_rerun_addr: got %0d bad addresses expected 0", addr_bad); end
    checks++; if (done_cyc !== 41) begin errors++; $display("[TB] FAIL midreset_rerun_done: got %0d expected 41", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_dual_nominal();
    test_solo();
    test_stalls();
    test_timeout();
    test_peer_boundary();
    test_reset_mid_tile();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
